// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MyCpu unified memory-port arbiter.
package mips_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [DEF_DATA_WIDTH/8-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory port between the instruction-fetch
// and data requesters; one access in flight, round-robin on conflicts.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ireq,
    input  logic [ADDR_WIDTH-1:0]   iaddr,
    output logic [DATA_WIDTH-1:0]   irdata,
    output logic                    iready,
    input  logic                    dreq,
    input  logic                    dwe,
    input  logic [ADDR_WIDTH-1:0]   daddr,
    input  logic [DATA_WIDTH-1:0]   dwdata,
    input  logic [DATA_WIDTH/8-1:0] dbe,
    output logic [DATA_WIDTH-1:0]   drdata,
    output logic                    dready,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [BE_W-1:0]  BE_ONES  = {BE_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    grant_t           last_grant;
    logic [CNT_W-1:0] cnt;
    logic             cmd_we;
    logic             grant_i;
    logic             grant_d;

    // On a conflict the port that did not win last time is served.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (ireq && (!dreq || last_grant == GNT_D)) begin
            grant_i = 1'b1;
        end else if (dreq) begin
            grant_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers double as the memory-side outputs so mem_* hold
    // their last issued values between accesses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_I;
            cnt        <= '0;
            cmd_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            irdata     <= '0;
            drdata     <= '0;
            iready     <= 1'b0;
            dready     <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            iready <= 1'b0;
            dready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_i) begin
                        last_grant <= GNT_I;
                        cmd_we     <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_addr   <= iaddr;
                        mem_be     <= BE_ONES;
                    end else if (grant_d) begin
                        last_grant <= GNT_D;
                        cmd_we     <= dwe;
                        mem_en     <= 1'b1;
                        mem_we     <= dwe;
                        mem_addr   <= daddr;
                        mem_be     <= dwe ? dbe : BE_ONES;
                        if (dwe) begin
                            mem_wdata <= dwdata;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (last_grant == GNT_I) begin
                        irdata <= mem_rdata;
                        iready <= 1'b1;
                    end else begin
                        if (!cmd_we) begin
                            drdata <= mem_rdata;
                        end
                        dready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on L=2 and L=1 instances plus
// a randomized run checked against a transaction-level timeline model.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int LA = 2;
    localparam int LB = 1;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dbe;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata, mem_rdata;
    logic        iready, dready, mem_en, mem_we;
    logic [3:0]  mem_be;

    logic        ireq_b, dreq_b, dwe_b;
    logic [31:0] iaddr_b, daddr_b, dwdata_b;
    logic [3:0]  dbe_b;
    logic [31:0] irdata_b, drdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        iready_b, dready_b, mem_en_b, mem_we_b;
    logic [3:0]  mem_be_b;

    logic [135:0] outs_a, outs_b;
    assign outs_a = {irdata, drdata, mem_addr, mem_wdata, mem_be, iready, dready, mem_en, mem_we};
    assign outs_b = {irdata_b, drdata_b, mem_addr_b, mem_wdata_b, mem_be_b,
                     iready_b, dready_b, mem_en_b, mem_we_b};

    mem_port_arbiter #(.MEM_LATENCY(LA), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_a (
        .clock(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
        .drdata(drdata), .dready(dready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(LB), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_b (
        .clock(clk), .reset(reset),
        .ireq(ireq_b), .iaddr(iaddr_b), .irdata(irdata_b), .iready(iready_b),
        .dreq(dreq_b), .dwe(dwe_b), .daddr(daddr_b), .dwdata(dwdata_b), .dbe(dbe_b),
        .drdata(drdata_b), .dready(dready_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_be(mem_be_b), .mem_rdata(mem_rdata_b)
    );

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 0) return 32'h2408_000A;
        return (32'(idx) * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] word_b(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hC0DE_0000;
    endfunction

    // Memory for instance A: 16 words indexed by address bits [5:2], latency LA.
    logic [31:0] mem_a [16];
    logic [31:0] pipe_a [LA];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem_a[mem_addr[5:2]] <= merge(mem_a[mem_addr[5:2]], mem_wdata, mem_be);
        end
        pipe_a[0] <= (mem_en && !mem_we) ? mem_a[mem_addr[5:2]] : $urandom;
        for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign mem_rdata = pipe_a[LA-1];

    // Read-only memory for instance B, latency LB = 1.
    logic [31:0] pipe_b;
    always @(posedge clk) pipe_b <= mem_en_b ? word_b(mem_addr_b) : $urandom;
    assign mem_rdata_b = pipe_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        iaddr = $urandom; daddr = $urandom; dwdata = $urandom; dbe = 4'($urandom);
        ireq_b = 1'b0; dreq_b = 1'b0; dwe_b = 1'b0;
        iaddr_b = $urandom; daddr_b = 32'h0; dwdata_b = 32'h0; dbe_b = 4'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1; mem_clear = 1'b1;
        tick(); tick();
        reset = 1'b0; mem_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ireq = $urandom; dreq = $urandom; dwe = $urandom;
            iaddr = $urandom; daddr = $urandom; dwdata = $urandom; dbe = 4'($urandom);
            ireq_b = $urandom; iaddr_b = $urandom;
            tick();
            n_vec++;
            if (outs_a !== '0) begin
                n_err++; $display("FAIL reset_outs_a: got %h want 0", outs_a);
            end
            n_vec++;
            if (outs_b !== '0) begin
                n_err++; $display("FAIL reset_outs_b: got %h want 0", outs_b);
            end
        end
        idle_inputs();
        reset = 1'b0; mem_clear = 1'b0;
        tick();
        n_vec++;
        if (outs_a !== '0) begin
            n_err++; $display("FAIL reset_idle_outs: got %h want 0", outs_a);
        end
    endtask

    task automatic test_fetch();
        ireq = 1'b1; iaddr = 32'h0040_0000; dreq = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_vec++;
            if (mem_en !== (k == 1)) begin
                n_err++; $display("FAIL fetch_mem_en c%0d: got %b want %b", k, mem_en, k == 1);
            end
            n_vec++;
            if (iready !== (k == 4)) begin
                n_err++; $display("FAIL fetch_iready c%0d: got %b want %b", k, iready, k == 4);
            end
            n_vec++;
            if (dready !== 1'b0) begin
                n_err++; $display("FAIL fetch_dready c%0d: got %b want 0", k, dready);
            end
            if (k == 1) begin
                n_vec++;
                if ({mem_addr, mem_be, mem_we} !== {32'h0040_0000, BE_ALL, 1'b0}) begin
                    n_err++; $display("FAIL fetch_cmd: got addr %h be %h we %b want 00400000 f 0",
                                      mem_addr, mem_be, mem_we);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (irdata !== 32'h2408_000A) begin
                    n_err++; $display("FAIL fetch_irdata: got %h want 2408000a", irdata);
                end
                ireq = 1'b0;
            end
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        ireq = 1'b1; iaddr = 32'h0000_1008;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_1004;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_vec++;
            if (mem_en !== (k == 1 || k == 6)) begin
                n_err++; $display("FAIL conflict_mem_en c%0d: got %b", k, mem_en);
            end
            n_vec++;
            if ({dready, iready} !== {k == 4, k == 9}) begin
                n_err++; $display("FAIL conflict_ready c%0d: got d%b i%b want d%b i%b",
                                  k, dready, iready, k == 4, k == 9);
            end
            if (k == 1 || k == 6) begin
                n_vec++;
                if (mem_addr !== ((k == 1) ? 32'h0000_1004 : 32'h0000_1008)) begin
                    n_err++; $display("FAIL conflict_addr c%0d: got %h", k, mem_addr);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (drdata !== init_word(1)) begin
                    n_err++; $display("FAIL conflict_drdata: got %h want %h", drdata, init_word(1));
                end
                dreq = 1'b0; daddr = $urandom;
            end
            if (k == 9) begin
                n_vec++;
                if (irdata !== init_word(2)) begin
                    n_err++; $display("FAIL conflict_irdata: got %h want %h", irdata, init_word(2));
                end
                ireq = 1'b0;
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] want_ld;
        want_ld = merge(init_word(0), 32'hDEAD_BEEF, 4'h3);
        for (int pass = 0; pass < 2; pass++) begin
            ireq = 1'b0; dreq = 1'b1; dwe = (pass == 0); daddr = 32'h1001_0000;
            dwdata = (pass == 0) ? 32'hDEAD_BEEF : $urandom;
            dbe = (pass == 0) ? 4'h3 : 4'($urandom);
            for (int k = 1; k <= 5; k++) begin
                tick();
                n_vec++;
                if ({mem_en, dready, iready} !== {k == 1, k == 4, 1'b0}) begin
                    n_err++; $display("FAIL store_ctl p%0d c%0d: got en%b d%b i%b",
                                      pass, k, mem_en, dready, iready);
                end
                if (k == 1 && pass == 0) begin
                    n_vec++;
                    if ({mem_we, mem_addr, mem_wdata, mem_be} !==
                        {1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 4'h3}) begin
                        n_err++; $display("FAIL store_cmd: got we%b %h %h %h",
                                          mem_we, mem_addr, mem_wdata, mem_be);
                    end
                end
                if (k == 1 && pass == 1) begin
                    n_vec++;
                    if ({mem_we, mem_be} !== {1'b0, BE_ALL}) begin
                        n_err++; $display("FAIL load_cmd: got we%b be %h want 0 f", mem_we, mem_be);
                    end
                end
                if (k == 4) begin
                    n_vec++;
                    if (drdata !== ((pass == 0) ? init_word(1) : want_ld)) begin
                        n_err++; $display("FAIL store_drdata p%0d: got %h want %h", pass, drdata,
                                          (pass == 0) ? init_word(1) : want_ld);
                    end
                    dreq = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_wait();
        ireq = 1'b0; dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_100C;
        tick();
        n_vec++;
        if (mem_en !== 1'b1) begin
            n_err++; $display("FAIL rstwait_first_en: got %b want 1", mem_en);
        end
        tick();
        reset = 1'b1;
        #1;
        n_vec++;
        if (outs_a !== '0) begin
            n_err++; $display("FAIL rstwait_async_clear: got %h want 0", outs_a);
        end
        tick();
        n_vec++;
        if (outs_a !== '0) begin
            n_err++; $display("FAIL rstwait_held: got %h want 0", outs_a);
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_vec++;
            if ({mem_en, dready, iready} !== {k == 1, k == 4, 1'b0}) begin
                n_err++; $display("FAIL rstwait_ctl c%0d: got en%b d%b i%b", k, mem_en, dready, iready);
            end
            if (k == 4) begin
                n_vec++;
                if (drdata !== init_word(3)) begin
                    n_err++; $display("FAIL rstwait_drdata: got %h want %h", drdata, init_word(3));
                end
                dreq = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cur;
        apply_reset();
        cur = $urandom & ~32'h3;
        ireq_b = 1'b1; iaddr_b = cur;
        for (int k = 1; k <= 24; k++) begin
            tick();
            n_vec++;
            if ({mem_en_b, iready_b, dready_b} !== {k % 4 == 1, k % 4 == 3, 1'b0}) begin
                n_err++; $display("FAIL b2b_ctl c%0d: got en%b i%b d%b", k, mem_en_b, iready_b, dready_b);
            end
            if (k % 4 == 1) begin
                n_vec++;
                if (mem_addr_b !== cur) begin
                    n_err++; $display("FAIL b2b_addr c%0d: got %h want %h", k, mem_addr_b, cur);
                end
            end
            if (k % 4 == 3) begin
                n_vec++;
                if (irdata_b !== word_b(cur)) begin
                    n_err++; $display("FAIL b2b_irdata c%0d: got %h want %h", k, irdata_b, word_b(cur));
                end
                cur = $urandom & ~32'h3;
                iaddr_b = cur;
            end
        end
        ireq_b = 1'b0;
    endtask

    task automatic test_random(input int ncyc);
        logic [31:0] ref_mem [16];
        logic [31:0] exp_ir, exp_dr, res, ex_addr, ex_wdata;
        logic [3:0]  ex_be;
        bit busy, own_d, last_d, st, en_x;
        int issue_c, done_c, free_c;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        apply_reset();
        exp_ir = '0; exp_dr = '0; res = '0; ex_addr = '0; ex_wdata = '0; ex_be = '0;
        busy = 0; own_d = 0; last_d = 0; st = 0;
        issue_c = -1; done_c = -1; free_c = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (busy && c == done_c) begin
                if (!own_d) exp_ir = res;
                else if (!st) exp_dr = res;
            end
            en_x = busy && c == issue_c;
            n_vec++;
            if ({mem_en, iready, dready} !== {en_x, busy && c == done_c && !own_d,
                                              busy && c == done_c && own_d}) begin
                n_err++; $display("FAIL rand_ctl c%0d: got en%b i%b d%b", c, mem_en, iready, dready);
            end
            n_vec++;
            if ({irdata, drdata} !== {exp_ir, exp_dr}) begin
                n_err++; $display("FAIL rand_rdata c%0d: got %h %h want %h %h",
                                  c, irdata, drdata, exp_ir, exp_dr);
            end
            if (en_x) begin
                n_vec++;
                if ({mem_addr, mem_we, mem_be} !== {ex_addr, st, ex_be} ||
                    (st && mem_wdata !== ex_wdata)) begin
                    n_err++; $display("FAIL rand_cmd c%0d: got %h we%b %h %h want %h we%b %h %h",
                                      c, mem_addr, mem_we, mem_be, mem_wdata, ex_addr, st, ex_be, ex_wdata);
                end
            end
            if (busy && c == done_c) begin
                busy = 0;
                free_c = c + 1;
                if (own_d) dreq = 1'b0;
                else ireq = 1'b0;
            end
            if (!ireq) begin
                iaddr = $urandom;
                if ($urandom_range(2) == 0) begin
                    ireq = 1'b1;
                    iaddr = 32'h0000_2000 | (32'($urandom_range(15)) << 2);
                end
            end
            if (!dreq) begin
                dwe = $urandom; daddr = $urandom; dwdata = $urandom; dbe = 4'($urandom);
                if ($urandom_range(2) == 0) begin
                    dreq = 1'b1;
                    daddr = 32'h0000_3000 | (32'($urandom_range(15)) << 2);
                end
            end
            if (!busy && c >= free_c && (ireq || dreq)) begin
                own_d = dreq && (!ireq || !last_d);
                last_d = own_d;
                busy = 1;
                issue_c = c + 1;
                done_c = c + LA + 2;
                if (own_d) begin
                    st = dwe; ex_addr = daddr; ex_wdata = dwdata;
                    ex_be = dwe ? dbe : BE_ALL;
                    if (dwe) ref_mem[daddr[5:2]] = merge(ref_mem[daddr[5:2]], dwdata, dbe);
                    else res = ref_mem[daddr[5:2]];
                end else begin
                    st = 0; ex_addr = iaddr; ex_be = BE_ALL;
                    res = ref_mem[iaddr[5:2]];
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        mem_clear = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_reset_wait();
        test_back_to_back();
        test_random(800);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
